// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared definitions for the multi-cycle HI/LO multiply/divide unit:
// MIPS function codes, the control state type and an opcode decode helper.
package mips_cpu_muldiv_pkg;

  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // True for the four codes that launch a multi-cycle operation
  function automatic logic isMulDiv(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

  // True for the codes that treat their operands as two's complement
  function automatic logic isSignedOp(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_DIV);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// MULT/MULTU/DIV/DIVU run on operand magnitudes (shift-add multiply,
// restoring divide), one bit per cycle, then a FIX cycle applies the sign
// correction and writes HI/LO. MTHI/MTLO write directly while idle.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Magnitude of a two's complement value; the most negative value maps to
  // 2^(WIDTH-1), which still fits because the result is read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] x);
    return -x;
  endfunction

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // acc: upper product half (multiply) or partial remainder (divide)
  // low: multiplier shifting out / quotient shifting in
  // opnd: multiplicand or divisor magnitude
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] aRaw_q, aRaw_d;
  logic             isDiv_q, isDiv_d;
  logic             negQ_q, negQ_d;
  logic             negRem_q, negRem_d;
  logic             divZero_q, divZero_d;

  logic             signedOp;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [2*WIDTH-1:0] prod;

  // Next-state, datapath step and write-back for the IDLE/RUN/FIX sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    low_d     = low_q;
    opnd_d    = opnd_q;
    aRaw_d    = aRaw_q;
    isDiv_d   = isDiv_q;
    negQ_d    = negQ_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    signedOp  = isSignedOp(op);
    addend    = low_q[0] ? opnd_q : '0;
    sum       = acc_q + {1'b0, addend};
    shifted   = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
    diff      = {1'b0, shifted} - {2'b00, opnd_q};
    ge        = ~diff[WIDTH+1];
    prod      = {acc_q[WIDTH-1:0], low_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (isMulDiv(op)) begin
            state_d   = RUN;
            cnt_d     = '0;
            acc_d     = '0;
            isDiv_d   = (op == FN_DIV) || (op == FN_DIVU);
            low_d     = signedOp ? magnitude(a) : a;
            opnd_d    = signedOp ? magnitude(b) : b;
            negQ_d    = signedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
            negRem_d  = signedOp & a[WIDTH-1];
            divZero_d = (b == '0);
            aRaw_d    = a;
          end else if (op == FN_MTHI) begin
            hi_d = a;
          end else if (op == FN_MTLO) begin
            lo_d = a;
          end
        end
      end

      RUN: begin
        if (isDiv_q) begin
          acc_d = ge ? diff[WIDTH:0] : shifted;
          low_d = {low_q[WIDTH-2:0], ge};
        end else begin
          acc_d = {1'b0, sum[WIDTH:1]};
          low_d = {sum[0], low_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (isDiv_q) begin
          if (divZero_q) begin
            lo_d = '1;
            hi_d = aRaw_q;
          end else begin
            lo_d = negQ_q ? negW(low_q) : low_q;
            hi_d = negRem_q ? negW(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
          end
        end else begin
          if (negQ_q) begin
            prod = neg2W({acc_q[WIDTH-1:0], low_q});
          end
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      low_q     <= '0;
      opnd_q    <= '0;
      aRaw_q    <= '0;
      isDiv_q   <= 1'b0;
      negQ_q    <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opnd_q    <= opnd_d;
      aRaw_q    <= aRaw_d;
      isDiv_q   <= isDiv_d;
      negQ_q    <= negQ_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv at WIDTH=32: a table of
// multiply/divide vectors plus hand-written MTHI/MTLO, busy-ignore and
// mid-operation reset sequences.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  localparam int WIDTH = 32;
  localparam int LATENCY = WIDTH + 1;
  localparam int MAX_WAIT = 100;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  op;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;
  logic [31:0] modelHi;
  logic [31:0] modelLo;
  vec_t vecs[12];

  mips_cpu_muldiv #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (aIn),
    .b    (bIn),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value and tally it
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issue one mul/div op and check latency, done pulse, HI/LO hold and result.
  // Optionally drives an MTLO while busy, which the unit must ignore.
  task automatic applyStimulus(input string tag, input logic [5:0] fn, input logic [31:0] av,
                               input logic [31:0] bv, input logic [31:0] expHi, input logic [31:0] expLo,
                               input logic injectMtlo);
    int busyCycles;
    int donePulses;
    @(negedge clk);
    start = 1'b1;
    op    = fn;
    aIn   = av;
    bIn   = bv;
    @(negedge clk);
    start = 1'b0;
    busyCycles = 0;
    donePulses = 0;
    while (busy && busyCycles < MAX_WAIT) begin
      busyCycles++;
      if (done) donePulses++;
      if (busyCycles == 10) begin
        checkOutput({tag, " hold hi"}, hi, modelHi);
        checkOutput({tag, " hold lo"}, lo, modelLo);
      end
      if (injectMtlo && busyCycles == 3) begin
        start = 1'b1;
        op    = FN_MTLO;
        aIn   = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({tag, " busy cycles"}, busyCycles, LATENCY);
    checkOutput({tag, " hi"}, hi, expHi);
    checkOutput({tag, " lo"}, lo, expLo);
    if (done) donePulses++;
    @(negedge clk);
    if (done) donePulses++;
    checkOutput({tag, " done pulses"}, donePulses, 1);
    modelHi = expHi;
    modelLo = expLo;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    modelHi = '0;
    modelLo = '0;
    start   = 1'b0;
    op      = '0;
    aIn     = '0;
    bIn     = '0;

    vecs[0]  = '{FN_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{FN_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[3]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{FN_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[6]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[7]  = '{FN_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[8]  = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{FN_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[11] = '{FN_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    // Power-on reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    checkOutput("reset busy", busy, 32'h0);
    checkOutput("reset done", done, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1;
    op    = FN_MTHI;
    aIn   = 32'h12345678;
    @(negedge clk);
    checkOutput("mthi hi", hi, 32'h12345678);
    checkOutput("mthi busy", busy, 32'h0);
    op  = FN_MTLO;
    aIn = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mtlo lo", lo, 32'h9ABCDEF0);
    checkOutput("mtlo hi kept", hi, 32'h12345678);
    checkOutput("mtlo busy", busy, 32'h0);
    checkOutput("mtlo done", done, 32'h0);
    modelHi = 32'h12345678;
    modelLo = 32'h9ABCDEF0;

    // Table-driven multiply/divide vectors
    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].expHi, vecs[i].expLo, 1'b0);
    end

    // MTLO issued while a MULT is in flight must be ignored
    applyStimulus("mult with mtlo", FN_MULT, 32'h00000003, 32'h00000005,
                  32'h00000000, 32'h0000000F, 1'b1);

    // Load nonzero HI/LO, then reset in the middle of a run
    applyStimulus("pre-reset", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFE, 32'h00000001, 1'b0);
    @(negedge clk);
    start = 1'b1;
    op    = FN_MULTU;
    aIn   = 32'hFFFFFFFF;
    bIn   = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("midrun busy", busy, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset hi", hi, 32'h0);
    checkOutput("async reset lo", lo, 32'h0);
    checkOutput("async reset busy", busy, 32'h0);
    begin
      int doneSeen;
      doneSeen = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (done) doneSeen++;
      end
      reset = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done || busy) doneSeen++;
      end
      checkOutput("reset no done", doneSeen, 0);
    end
    modelHi = '0;
    modelLo = '0;

    // Fresh operation after the abort
    applyStimulus("post-reset multu", FN_MULTU, 32'h00000003, 32'h00000005,
                  32'h00000000, 32'h0000000F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Parametrised, multi-cycle multiply/divide unit owning the HI/LO register pair. It replaces the single-cycle HI/LO block, and each MULT/MULTU/DIV/DIVU takes WIDTH+1 cycles. During that time the unit raises `busy` so the CPU control can stall MFHI/MFLO and any further HI/LO operation. MTHI/MTLO complete in one cycle.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be at least 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `op`  in  6  MIPS function code: 010001 MTHI, 010011 MTLO, 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU. Other codes are ignored.
- `a`  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO source.
- `b`  in  WIDTH  rt value: multiplier or divisor.
- `busy`  out  1  high while a multiply or divide is in flight.
- `done`  out  1  one-cycle pulse after HI/LO are written by a multiply or divide.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- States:
  - IDLE: accepts `start`.
  - RUN: iterates.
  - FIX: sign correction and write-back.
- Transitions:
  - IDLE→RUN when `start` is high and `op` is a mul/div code.
  - RUN→FIX after WIDTH iterations.
  - FIX→IDLE unconditionally.
- MTHI/MTLO in IDLE with `start`: writes `hi` (or `lo`) with `a` at that edge. State stays IDLE, no `done`, no `busy`.
- Operand latch at accept:
  - Signed ops latch |a| and |b| plus the result sign flags.
  - Unsigned ops latch the raw values.
  - The magnitude of the most negative value is 2^(WIDTH-1), held unsigned.
- Multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH product register. FIX negates the product when the sign flags differ, then `hi` = upper WIDTH bits and `lo` = lower WIDTH bits.
- Divide: restoring, one quotient bit per cycle, using a WIDTH+1-bit partial remainder.
  - FIX negates the quotient if the operand signs differ and negates the remainder if the dividend is negative, giving truncation toward zero.
  - `lo` = quotient, `hi` = remainder.
- Divide by zero, both DIV and DIVU: `lo` = all ones, `hi` = `a` as latched (unsigned raw, signed original value). The unit still takes the full latency and there is no exception.
- Signed overflow, most-negative ÷ −1: `lo` = most-negative, `hi` = 0. This falls out of the magnitude path and needs no special-casing.
- `start` while `busy`=1 is ignored, including MTHI/MTLO. The CPU must stall.
- `hi`/`lo` hold their old values throughout RUN and change only at the FIX edge.
- Reset asserted mid-operation aborts at once and applies the reset values. No `done` is produced.

## Timing
- Accept edge E0: `busy` goes high after E0.
- RUN occupies edges E1..E_WIDTH.
- FIX edge E_(WIDTH+1): `hi`/`lo` are written, `busy` drops, and `done` is high for the following cycle.
- `busy` is high for exactly WIDTH+1 cycles.
- A new `start` is accepted on the edge right after `busy` falls. Back-to-back throughput is one op per WIDTH+2 cycles.
- MTHI/MTLO: result visible on `hi`/`lo` the cycle after the accept edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `mips_cpu_muldiv_pkg`:
  - function-code localparams: FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU;
  - state enum `muldiv_state_t` {IDLE, RUN, FIX}.
- Single module. The iteration counter is $clog2(WIDTH+1) bits wide.
- No sub-module is required. Sign magnitude and negation are local functions.

## Test plan
Test plan uses WIDTH=32.
- MULT a=FFFFFFFF, b=00000002 → after 33 busy cycles, `hi`=FFFFFFFF, `lo`=FFFFFFFE, `done` pulses once.
- MULTU a=FFFFFFFF, b=00000002 → `hi`=00000001, `lo`=FFFFFFFE. Also MULTU FFFFFFFF×FFFFFFFF → `hi`=FFFFFFFE, `lo`=00000001.
- DIV cases:
  - DIV a=FFFFFFF9 (−7), b=2 → `lo`=FFFFFFFD, `hi`=FFFFFFFF.
  - DIV 80000000 / FFFFFFFF → `lo`=80000000, `hi`=0.
- DIVU a=7, b=0 → `lo`=FFFFFFFF, `hi`=00000007 after the full latency.
- MTHI a=12345678, then MTLO a=9ABCDEF0 on consecutive cycles → `hi`/`lo` updated one cycle each, `busy` stays 0. A MTLO issued during a MULT is ignored.
- Reset:
  - `reset` pulled low at RUN cycle 10 → `hi`=`lo`=0, `busy`=0 asynchronously, and no `done`.
  - A subsequent MULTU 3×5 → `lo`=0000000F, `hi`=0.
